// File: rtl/finish_rr_arbiter.sv
// Round-robin arbiter that merges per-requester finish messages into a single
// one-entry output register. The entry refills in the same cycle it drains.
module finish_rr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned XACT_W = 2,
    localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          in_valid,
    output logic [N_REQ-1:0]          in_ready,
    input  logic [N_REQ*XACT_W-1:0]   in_xact_id,
    input  logic [N_REQ-1:0]          in_manager_id,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XACT_W-1:0]         out_xact_id,
    output logic                      out_manager_id,
    output logic [SRC_W-1:0]          out_src,
    output logic [15:0]               grant_cnt
);

    logic              full_q;
    logic [XACT_W-1:0] xact_q;
    logic              mgr_q;
    logic [SRC_W-1:0]  src_q;
    logic [SRC_W-1:0]  rr_ptr_q;
    logic [15:0]       cnt_q;

    logic              acc_en;
    logic              any_valid;
    logic              enq;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  idx;

    // Winner search: first valid requester starting at rr_ptr, wrapping.
    // Scanning from the far end lets the nearest valid index win last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = SRC_W'(rr_ptr_q + SRC_W'(k));
            if (in_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // Handshake decode; no handshake may complete while reset is asserted.
    always_comb begin
        acc_en   = !full_q || out_ready;
        enq      = acc_en && any_valid && !reset;
        in_ready = '0;
        if (enq) begin
            in_ready[winner] = 1'b1;
        end
    end

    // Output register, round-robin pointer and grant counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= 1'b0;
            xact_q   <= '0;
            mgr_q    <= 1'b0;
            src_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (enq) begin
            full_q   <= 1'b1;
            xact_q   <= in_xact_id[winner*XACT_W +: XACT_W];
            mgr_q    <= in_manager_id[winner];
            src_q    <= winner;
            rr_ptr_q <= SRC_W'(winner + SRC_W'(1));
            cnt_q    <= cnt_q + 16'd1;
        end else if (full_q && out_ready) begin
            // Drain only: data registers keep their last value.
            full_q <= 1'b0;
        end
    end

    assign out_valid      = full_q;
    assign out_xact_id    = xact_q;
    assign out_manager_id = mgr_q;
    assign out_src        = src_q;
    assign grant_cnt      = cnt_q;

endmodule
